ila_mem_capture: RTL and testbench
==================================

Name: ila_mem_capture

Overview:
- On-chip logic-analyzer capture block that records snapshots of sixteen register-file probe buses into an internal sample buffer after a programmable trigger.
- Sits beside the register file: the probes connect to registers x0..x15, and a debug host arms the block, then reads the captured samples back through a registered read port.
- Passive: never drives or stalls the observed logic.

Parameters:
- DATA_WIDTH, 32: width of each probe bus and of rd_data.
- DEPTH, 16: number of samples captured per trigger; must be a power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH): width of rd_addr and sample_count index (derived).

Ports:
- clk  input  1  capture and readout clock; all logic is on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- probe0..probe15  input  DATA_WIDTH each  observed buses, sampled every clk.
- arm  input  1  one-cycle pulse; starts a new acquisition.
- trig_sel  input  4  index of the probe compared for the trigger.
- trig_mask  input  DATA_WIDTH  bit mask for the trigger compare.
- trig_value  input  DATA_WIDTH  trigger compare value.
- rd_addr  input  ADDR_WIDTH  sample index to read (0 = trigger sample).
- rd_sel  input  4  probe index to read within that sample.
- rd_data  output  DATA_WIDTH  registered readout data.
- armed  output  1  high in ARMED state.
- capturing  output  1  high in CAPTURE state.
- done  output  1  high in DONE state.
- sample_count  output  ADDR_WIDTH+1  samples stored in the current/last acquisition.

Behaviour:
- Reset: state IDLE; armed, capturing and done are 0; sample_count is 0; rd_data is 0. Buffer contents are not cleared and are undefined after power-up.
- States:
  - IDLE: arm moves to ARMED next cycle and clears sample_count to 0.
  - ARMED: each cycle, evaluate hit = ((probe[trig_sel] & trig_mask) == (trig_value & trig_mask)). On hit, the same-cycle probe values are written to buffer slot 0, sample_count becomes 1, and the state moves to CAPTURE.
  - CAPTURE: each cycle, write all 16 probes to slot sample_count and increment it. When the write fills slot DEPTH-1, sample_count = DEPTH and the state moves to DONE.
  - DONE: hold the buffer. arm re-enters ARMED and clears sample_count.
- Trigger operands (trig_sel, trig_mask, trig_value) are sampled live each cycle; no latching.
- A trig_mask of 0 triggers on the first ARMED cycle.
- arm asserted while in ARMED or CAPTURE is ignored.
- Each sample stores all sixteen probes (16 × DATA_WIDTH bits) captured on the same clk edge.
- Readout: rd_data <= buffer[rd_addr].probe[rd_sel] every cycle, one-cycle latency, in any state. Reading a slot ≥ sample_count returns stale contents.
- Readout of a slot being written in the same cycle returns the old contents (read-before-write).
- rst mid-acquisition aborts to IDLE with sample_count 0; buffer is left as is.
- Status outputs are registered state decodes; exactly one of armed, capturing or done is high, or none in IDLE.

Test Plan:
- Reset, then hold all inputs 0 -> armed=capturing=done=0, sample_count=0, rd_data=0.
- trig_mask=0, pulse arm, probe3 = cycle counter starting at 100 -> trigger on the first ARMED cycle; done after 16 captures; reading rd_sel=3 for addr 0..15 returns consecutive values.
- trig_sel=5, trig_mask=0xFFFFFFFF, trig_value=0xDEADBEEF; probe5 = 0 for 7 cycles, then 0xDEADBEEF -> armed for 7 cycles, capturing next; addr 0, sel 5 reads 0xDEADBEEF.
- Masked trigger: trig_mask=0x000000FF, trig_value=0x12, probe0=0xAB000012 -> triggers; probe0=0x00000013 -> no trigger.
- Pulse arm during CAPTURE -> ignored, sample_count keeps incrementing to 16.
- Assert rst at sample_count=5 -> IDLE, sample_count=0; re-arm captures normally.
- Readout latency: change rd_addr from 2 to 7 -> rd_data reflects slot 7 exactly one cycle later.

Source files
------------

// File: rtl/ila_mem_capture.sv
// ila_mem_capture: logic-analyzer capture of sixteen register-file probe buses.
// Once armed, it waits for a masked compare on one selected probe. It then
// records DEPTH consecutive snapshots of all probes, with slot 0 holding the
// trigger cycle. The host reads samples back through a one-cycle registered port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no acquisition; waiting for arm
// ARMED   | evaluating trigger compare every cycle
// CAPTURE | writing one snapshot per cycle into slot sample_count
// DONE    | buffer full and held; arm starts a new acquisition
module ila_mem_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] probe0,
    input  logic [DATA_WIDTH-1:0] probe1,
    input  logic [DATA_WIDTH-1:0] probe2,
    input  logic [DATA_WIDTH-1:0] probe3,
    input  logic [DATA_WIDTH-1:0] probe4,
    input  logic [DATA_WIDTH-1:0] probe5,
    input  logic [DATA_WIDTH-1:0] probe6,
    input  logic [DATA_WIDTH-1:0] probe7,
    input  logic [DATA_WIDTH-1:0] probe8,
    input  logic [DATA_WIDTH-1:0] probe9,
    input  logic [DATA_WIDTH-1:0] probe10,
    input  logic [DATA_WIDTH-1:0] probe11,
    input  logic [DATA_WIDTH-1:0] probe12,
    input  logic [DATA_WIDTH-1:0] probe13,
    input  logic [DATA_WIDTH-1:0] probe14,
    input  logic [DATA_WIDTH-1:0] probe15,
    input  logic                  arm,
    input  logic [3:0]            trig_sel,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [3:0]            rd_sel,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  armed,
    output logic                  capturing,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   sample_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // The write that lands in slot DEPTH-1 completes the acquisition.
    localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    state_t state;
    state_t state_next;

    logic [15:0][DATA_WIDTH-1:0] probe_bus;
    logic [15:0][DATA_WIDTH-1:0] sample_mem [DEPTH];

    logic                  hit;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_slot;

    assign probe_bus = {probe15, probe14, probe13, probe12, probe11, probe10, probe9, probe8,
                        probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0};

    // Trigger operands are used live, so the host may retune them while armed.
    assign hit = ((probe_bus[trig_sel] & trig_mask) == (trig_value & trig_mask));

    assign wr_en   = ((state == ARMED) && hit) || (state == CAPTURE);
    assign wr_slot = (state == ARMED) ? '0 : sample_count[ADDR_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; arm is ignored while an acquisition is in flight.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm) state_next = ARMED;
            ARMED:   if (hit) state_next = CAPTURE;
            CAPTURE: if (sample_count == LAST_SLOT) state_next = DONE;
            DONE:    if (arm) state_next = ARMED;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decode the registered state directly.
    always_comb begin
        armed     = (state == ARMED);
        capturing = (state == CAPTURE);
        done      = (state == DONE);
    end

    // Number of snapshots stored in the current or last acquisition.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (arm) sample_count <= '0;
                ARMED:      if (hit) sample_count <= (ADDR_WIDTH + 1)'(1);
                CAPTURE:    sample_count <= sample_count + 1'b1;
                default:    sample_count <= sample_count;
            endcase
        end
    end

    // Sample buffer write. It has no reset, so a reset leaves the last capture readable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            sample_mem[wr_slot] <= probe_bus;
        end
    end

    // Registered readout. It reads before the write, so a slot written this edge returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= sample_mem[rd_addr][rd_sel];
        end
    end

endmodule

// File: tb/tb_ila_mem_capture.sv
// Directed bench for ila_mem_capture. Inputs change on the falling edge and
// outputs are checked on the falling edge, half a period after the DUT edge.
module tb_ila_mem_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] probe [16];
    logic        arm;
    logic [3:0]  trig_sel;
    logic [31:0] trig_mask;
    logic [31:0] trig_value;
    logic [3:0]  rd_addr;
    logic [3:0]  rd_sel;
    logic [31:0] rd_data;
    logic        armed;
    logic        capturing;
    logic        done;
    logic [4:0]  sample_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ila_mem_capture #(.DATA_WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .probe0(probe[0]),   .probe1(probe[1]),   .probe2(probe[2]),   .probe3(probe[3]),
        .probe4(probe[4]),   .probe5(probe[5]),   .probe6(probe[6]),   .probe7(probe[7]),
        .probe8(probe[8]),   .probe9(probe[9]),   .probe10(probe[10]), .probe11(probe[11]),
        .probe12(probe[12]), .probe13(probe[13]), .probe14(probe[14]), .probe15(probe[15]),
        .arm(arm), .trig_sel(trig_sel), .trig_mask(trig_mask), .trig_value(trig_value),
        .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
        .armed(armed), .capturing(capturing), .done(done), .sample_count(sample_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One rising edge, then return at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic a, input logic c, input logic d,
                                input logic [4:0] cnt);
        check_eq({tag, ".armed"}, 32'(armed), 32'(a));
        check_eq({tag, ".capturing"}, 32'(capturing), 32'(c));
        check_eq({tag, ".done"}, 32'(done), 32'(d));
        check_eq({tag, ".count"}, 32'(sample_count), 32'(cnt));
    endtask

    // Wait a bounded number of cycles for done. If the limit expires, the final check reports it.
    task automatic wait_done(input string tag);
        for (int i = 0; i < 24 && !done; i++) tick();
        check_status(tag, 1'b0, 1'b0, 1'b1, 5'd16);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig_sel = '0; trig_mask = '0; trig_value = '0;
        rd_addr = '0; rd_sel = '0;
        for (int i = 0; i < 16; i++) probe[i] = '0;
        @(negedge clk);
        tick();
        tick();
        check_status("reset", 1'b0, 1'b0, 1'b0, 5'd0);
        check_eq("reset.rd_data", rd_data, 32'h0);
        rst = 1'b0;
        tick();
        check_status("idle", 1'b0, 1'b0, 1'b0, 5'd0);

        // mask 0: trigger on the first ARMED cycle, probe3 counts from 100
        trig_mask = '0; arm = 1'b1;
        tick();
        arm = 1'b0;
        check_status("m0.armed", 1'b1, 1'b0, 1'b0, 5'd0);
        probe[3] = 32'd100;
        tick();
        check_status("m0.trig", 1'b0, 1'b1, 1'b0, 5'd1);
        for (int i = 1; i < 16; i++) begin
            probe[3] = 32'd100 + 32'(i);
            tick();
        end
        check_status("m0.done", 1'b0, 1'b0, 1'b1, 5'd16);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); rd_sel = 4'd3;
            tick();
            check_eq($sformatf("m0.read%0d", a), rd_data, 32'd100 + 32'(a));
        end

        // full-mask compare on probe5: armed for 7 cycles, then trigger
        trig_sel = 4'd5; trig_mask = 32'hFFFF_FFFF; trig_value = 32'hDEAD_BEEF;
        probe[5] = '0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check_status($sformatf("p5.wait%0d", i), 1'b1, 1'b0, 1'b0, 5'd0);
            tick();
        end
        probe[5] = 32'hDEAD_BEEF;
        tick();
        check_status("p5.trig", 1'b0, 1'b1, 1'b0, 5'd1);
        probe[5] = 32'h0;
        wait_done("p5.done");
        rd_addr = 4'd0; rd_sel = 4'd5;
        tick();
        check_eq("p5.slot0", rd_data, 32'hDEAD_BEEF);
        rd_addr = 4'd1;
        tick();
        check_eq("p5.slot1", rd_data, 32'h0);

        // masked compare on probe0 (low byte 0x12), with an arm pulse during capture
        trig_sel = 4'd0; trig_mask = 32'h0000_00FF; trig_value = 32'h12;
        probe[0] = 32'h0000_0013; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_status($sformatf("mask.miss%0d", i), 1'b1, 1'b0, 1'b0, 5'd0);
        end
        probe[0] = 32'hAB00_0012;
        tick();
        check_status("mask.hit", 1'b0, 1'b1, 1'b0, 5'd1);
        probe[0] = 32'h0;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_status("armcap.ignored", 1'b0, 1'b1, 1'b0, 5'd3);
        tick();
        check_eq("armcap.count4", 32'(sample_count), 32'd4);
        wait_done("armcap.done");
        rd_addr = 4'd0; rd_sel = 4'd0;
        tick();
        check_eq("mask.slot0", rd_data, 32'hAB00_0012);

        // reset mid-capture at sample_count 5, then capture again
        trig_mask = '0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            probe[7] = 32'd300 + 32'(k);
            tick();
        end
        check_status("abort.pre", 1'b0, 1'b1, 1'b0, 5'd5);
        rst = 1'b1;
        tick();
        check_status("abort.rst", 1'b0, 1'b0, 1'b0, 5'd0);
        check_eq("abort.rd_data", rd_data, 32'h0);
        rst = 1'b0;
        rd_addr = 4'd4; rd_sel = 4'd7;
        tick();
        check_status("abort.idle", 1'b0, 1'b0, 1'b0, 5'd0);
        check_eq("abort.kept", rd_data, 32'd304);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 0; k < 16; k++) begin
            probe[7] = 32'd500 + 32'(k);
            tick();
        end
        check_status("rearm.done", 1'b0, 1'b0, 1'b1, 5'd16);
        rd_addr = 4'd15;
        tick();
        check_eq("rearm.slot15", rd_data, 32'd515);

        // readout latency: switch the address from 2 to 7
        rd_addr = 4'd2;
        tick();
        check_eq("lat.slot2", rd_data, 32'd502);
        rd_addr = 4'd7;
        #1;
        check_eq("lat.hold", rd_data, 32'd502);
        tick();
        check_eq("lat.slot7", rd_data, 32'd507);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
